// File: rtl/y86_cycle_sequencer.sv
// Multi-cycle Y86-64 control FSM: one instruction at a time, one stage enable per cycle, sticky halt.
// 5 cycles/instr without a memory stage, 6 with; each memory wait cycle adds 1 and is bounded by TIMEOUT.
module y86_cycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [2:0]       stat,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       halt_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALTED    = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]       halt_code_q, halt_code_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic mem_op;
  logic mem_wr;
  logic expired;

  always_comb begin
    mem_op  = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    mem_wr  = icode inside {4'h4, 4'h8, 4'hA};
    // A req that has already waited TIMEOUT-1 cycles expires this cycle unless acked now.
    expired = (wait_q == WAIT_LAST);
  end

  always_comb begin
    state_d       = state_q;
    halt_code_d   = halt_code_q;
    instr_count_d = instr_count_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    f_en          = 1'b0;
    d_en          = 1'b0;
    e_en          = 1'b0;
    m_en          = 1'b0;
    w_en          = 1'b0;
    pc_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          f_en    = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d     = S_HALTED;
          halt_code_d = STAT_ADR;
        end
      end
      S_DECODE: begin
        d_en = 1'b1;
        if (stat != STAT_AOK) begin
          state_d     = S_HALTED;
          halt_code_d = stat;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        e_en    = 1'b1;
        state_d = mem_op ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = mem_wr;
        if (dmem_ack) begin
          m_en = 1'b1;
          if (stat != STAT_AOK) begin
            state_d     = S_HALTED;
            halt_code_d = stat;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (expired) begin
          state_d     = S_HALTED;
          halt_code_d = STAT_ADR;
        end
      end
      S_WRITEBACK: begin
        w_en    = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_we         = 1'b1;
        instr_count_d = instr_count_q + 1'b1;
        state_d       = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEMORY)))
      wait_d = wait_q + 1'b1;
    else
      wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      halt_code_q   <= STAT_AOK;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      halt_code_q   <= halt_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted      = (state_q == S_HALTED);
  assign halt_code   = halt_code_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_y86_cycle_sequencer.sv
// Directed bench for y86_cycle_sequencer; inputs change at posedge+1, outputs checked at posedge+2.
module tb_y86_cycle_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, imem_ack, dmem_ack;
  logic [3:0]  icode;
  logic [2:0]  stat;
  logic        imem_req, dmem_req, dmem_we;
  logic        f_en, d_en, e_en, m_en, w_en, pc_we;
  logic        busy, halted;
  logic [2:0]  halt_code;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;
  localparam logic [5:0] EN_0 = 6'b000000;

  y86_cycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .stat(stat),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_we(pc_we),
    .busy(busy), .halted(halted), .halt_code(halt_code), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [5:0] en;
  assign en = {f_en, d_en, e_en, m_en, w_en, pc_we};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    stat = 3'd1; icode = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // From IDLE: pulse start, land settled in FETCH.
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
  endtask

  // Entered settled in FETCH with imem_ack=1; leaves settled in the next FETCH.
  task automatic run_nonmem(input logic [3:0] ic);
    chk("nm_f", en, EN_F);
    tick(); icode = ic; settle();
    chk("nm_d", en, EN_D);
    tick(); settle();
    chk("nm_e", en, EN_E);
    tick(); settle();
    chk("nm_w", en, EN_W);
    tick(); settle();
    chk("nm_p", en, EN_P);
    tick(); settle();
    chk("nm_f2", en, EN_F);
  endtask

  initial begin
    do_reset();
    chk("rst_en", en, EN_0);
    chk("rst_ireq", imem_req, 1'b0);
    chk("rst_dreq", dmem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_code", halt_code, 3'd1);
    chk("rst_cnt", instr_count, 32'd0);

    // irmovq with immediate fetch acks
    imem_ack = 1'b1;
    kick();
    chk("t1_busy", busy, 1'b1);
    chk("t1_ireq", imem_req, 1'b1);
    run_nonmem(4'h3);
    chk("t1_cnt", instr_count, 32'd1);

    // rmmovq, dmem_ack arrives in the third MEMORY cycle
    tick(); icode = 4'h4; settle();
    chk("t2_d", en, EN_D);
    tick(); settle();
    chk("t2_e", en, EN_E);
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("t2_wait_en", en, EN_0);
      chk("t2_wait_req", dmem_req, 1'b1);
      chk("t2_wait_we", dmem_we, 1'b1);
    end
    tick(); dmem_ack = 1'b1; settle();
    chk("t2_m", en, EN_M);
    chk("t2_m_req", dmem_req, 1'b1);
    chk("t2_m_we", dmem_we, 1'b1);
    tick(); dmem_ack = 1'b0; settle();
    chk("t2_w", en, EN_W);
    chk("t2_w_req", dmem_req, 1'b0);
    tick(); settle();
    chk("t2_p", en, EN_P);
    tick(); settle();
    chk("t2_cnt", instr_count, 32'd2);
    chk("t2_f", en, EN_F);

    // popq faulting with ADR on the data access
    tick(); icode = 4'hB; settle();
    chk("t6_d", en, EN_D);
    tick(); settle();
    chk("t6_e", en, EN_E);
    tick(); dmem_ack = 1'b1; stat = 3'd3; settle();
    chk("t6_m", en, EN_M);
    chk("t6_we", dmem_we, 1'b0);
    tick(); dmem_ack = 1'b0; start = 1'b1; settle();
    chk("t6_halted", halted, 1'b1);
    chk("t6_code", halt_code, 3'd3);
    chk("t6_en", en, EN_0);
    chk("t6_cnt", instr_count, 32'd2);
    chk("t6_busy", busy, 1'b0);
    tick(); tick(); settle();
    chk("t6_sticky", halted, 1'b1);
    chk("t6_ireq", imem_req, 1'b0);
    start = 1'b0; stat = 3'd1;

    do_reset();
    chk("rh_halted", halted, 1'b0);
    chk("rh_code", halt_code, 3'd1);
    chk("rh_cnt", instr_count, 32'd0);

    // reset while a load is waiting in MEMORY
    imem_ack = 1'b1;
    kick();
    run_nonmem(4'h3);
    chk("t5_cnt1", instr_count, 32'd1);
    tick(); icode = 4'h5; settle();
    tick(); settle();
    tick(); settle();
    chk("t5_dreq", dmem_req, 1'b1);
    chk("t5_we", dmem_we, 1'b0);
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    chk("t5_dreq_off", dmem_req, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_cnt", instr_count, 32'd0);
    chk("t5_code", halt_code, 3'd1);

    // halt instruction reports HLT in DECODE
    kick();
    run_nonmem(4'h3);
    tick(); icode = 4'h0; stat = 3'd2; settle();
    chk("t3_d", en, EN_D);
    tick(); start = 1'b1; settle();
    chk("t3_halted", halted, 1'b1);
    chk("t3_code", halt_code, 3'd2);
    chk("t3_cnt", instr_count, 32'd1);
    tick(); settle();
    chk("t3_sticky", halted, 1'b1);
    chk("t3_busy", busy, 1'b0);
    start = 1'b0; stat = 3'd1;

    // fetch never acked: four req cycles, then ADR
    do_reset();
    kick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_ireq", imem_req, 1'b1);
      chk("t4_nothalt", halted, 1'b0);
      tick(); settle();
    end
    chk("t4_halted", halted, 1'b1);
    chk("t4_code", halt_code, 3'd3);
    chk("t4_ireq_off", imem_req, 1'b0);

    // ack in the expiry cycle wins over the timeout
    do_reset();
    kick();
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
    end
    imem_ack = 1'b1; settle();
    chk("tb_f", en, EN_F);
    tick(); settle();
    chk("tb_nothalt", halted, 1'b0);
    chk("tb_d", en, EN_D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
